video_timing_gen: RTL and testbench

Parametrised raster timing generator that drives the HDMI/VGA transmitter and paces the PPU row renderer. Runs on the single 50 MHz system clock with a pixel clock-enable, so it replaces the fixed 640x480 timing logic inside the HDMI output with one configurable block. It produces sync, data-enable and scaled pixel coordinates for the transmitter, plus the PPU-facing strobes `rowram_swap`, `vblank_start`, `vblank_end_soon` and `next_row`. Integer pixel scaling (line/pixel repeat) is included.

---
 rtl/video_timing_pkg.sv | 24 ++
 rtl/video_timing_gen_if.sv | 35 +++
 rtl/video_axis_counter.sv | 48 ++++
 rtl/video_timing_gen.sv | 129 ++++++++++++
 tb/tb_video_timing_gen.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - shared timing constants, counter types and helpers for the raster generator.
package video_timing_pkg;

  localparam int DEF_H_ACTIVE   = 640;
  localparam int DEF_H_FP       = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BP       = 48;
  localparam int DEF_V_ACTIVE   = 480;
  localparam int DEF_V_FP       = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BP       = 33;
  localparam int DEF_SCALE      = 2;
  localparam int DEF_SOON_LINES = 2;
  localparam int DEF_HS_POL     = 0;
  localparam int DEF_VS_POL     = 0;

  typedef logic [9:0] hcount_t;
  typedef logic [9:0] vcount_t;

  function automatic int vtg_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - video/PPU output bundle of the timing generator.
// frame_count exists only when VTG_FRAME_COUNT_EN is defined.
interface video_timing_gen_if;
  import video_timing_pkg::*;

  logic       vga_de;
  logic       vga_hs;
  logic       vga_vs;
  hcount_t    pixel_x;
  vcount_t    pixel_y;
  logic       rowram_swap;
  logic [7:0] next_row;
  logic       vblank_start;
  logic       vblank_end_soon;
`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  modport master (
    output vga_de, vga_hs, vga_vs, pixel_x, pixel_y,
    output rowram_swap, next_row, vblank_start, vblank_end_soon
`ifdef VTG_FRAME_COUNT_EN
    , output frame_count
`endif
  );

  modport slave (
    input vga_de, vga_hs, vga_vs, pixel_x, pixel_y,
    input rowram_swap, next_row, vblank_start, vblank_end_soon
`ifdef VTG_FRAME_COUNT_EN
    , input frame_count
`endif
  );

endinterface

// File: rtl/video_axis_counter.sv
// rtl/video_axis_counter.sv - one raster axis: wrapping position counter with next-state
// active and sync decode, so the top can register outputs in step with the count.
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE    = 640,
  parameter int FP        = 16,
  parameter int SYNC      = 96,
  parameter int BP        = 48,
  parameter int POL       = 0,
  parameter int RESET_VAL = 0
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    inc,
  output hcount_t count,
  output hcount_t next_count,
  output logic    wrap,
  output logic    active,
  output logic    sync
);

  localparam int      TOTAL      = vtg_total(ACTIVE, FP, SYNC, BP);
  localparam hcount_t LAST       = hcount_t'(TOTAL - 1);
  localparam hcount_t SYNC_START = hcount_t'(ACTIVE + FP);
  localparam hcount_t SYNC_END   = hcount_t'(ACTIVE + FP + SYNC);
  localparam logic    SYNC_LVL   = (POL != 0);

  always_comb begin
    wrap       = inc && (count == LAST);
    next_count = count;
    if (inc) begin
      next_count = wrap ? '0 : count + 10'd1;
    end
  end

  assign active = (next_count < hcount_t'(ACTIVE));
  assign sync   = ((next_count >= SYNC_START) && (next_count < SYNC_END)) ? SYNC_LVL : ~SYNC_LVL;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= hcount_t'(RESET_VAL);
    end else begin
      count <= next_count;
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - configurable raster timing generator with pixel/line scaling and PPU strobes.
// Optional frame counter output enabled by defining VTG_FRAME_COUNT_EN.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int SCALE      = DEF_SCALE,
  parameter int SOON_LINES = DEF_SOON_LINES,
  parameter int HS_POL     = DEF_HS_POL,
  parameter int VS_POL     = DEF_VS_POL
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_ce,
  video_timing_gen_if.master  vid
);

  localparam int   H_TOTAL = vtg_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int   V_TOTAL = vtg_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int   ROWS    = V_ACTIVE / SCALE;
  localparam logic HS_LVL  = (HS_POL != 0);
  localparam logic VS_LVL  = (VS_POL != 0);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_err_total
    $error("video_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (ROWS > 256) begin : g_err_rows
    $error("video_timing_gen: V_ACTIVE/SCALE must not exceed 256");
  end
  if (SCALE != 1 && SCALE != 2 && SCALE != 4) begin : g_err_scale
    $error("video_timing_gen: SCALE must be 1, 2 or 4");
  end
  if ((H_ACTIVE % SCALE) != 0 || (V_ACTIVE % SCALE) != 0) begin : g_err_mult
    $error("video_timing_gen: H_ACTIVE and V_ACTIVE must be multiples of SCALE");
  end
  if (SOON_LINES < 1 || SOON_LINES > (V_FP + V_SYNC + V_BP)) begin : g_err_soon
    $error("video_timing_gen: SOON_LINES out of range");
  end

  hcount_t h_count, h_next;
  vcount_t v_count, v_next;
  logic    h_wrap, h_act, h_sync;
  logic    v_wrap, v_act, v_sync;

  video_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HS_POL), .RESET_VAL(H_TOTAL - 1)
  ) u_h_axis (
    .clk(clk), .rst(rst), .inc(pix_ce),
    .count(h_count), .next_count(h_next), .wrap(h_wrap),
    .active(h_act), .sync(h_sync)
  );

  video_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VS_POL), .RESET_VAL(V_ACTIVE - 1)
  ) u_v_axis (
    .clk(clk), .rst(rst), .inc(h_wrap),
    .count(v_count), .next_count(v_next), .wrap(v_wrap),
    .active(v_act), .sync(v_sync)
  );

  logic unused_axis;
  assign unused_axis = ^{h_count, v_count, v_wrap};

  vcount_t    line_n;
  logic [8:0] row_calc;
  logic       de_next;
  logic       swap_hit;
  logic       vbs_hit;
  logic       soon_hit;

  // Strobes qualify on pix_ce so they mark entry into a position, never dwelling on it.
  always_comb begin
    line_n   = (v_next == vcount_t'(V_TOTAL - 1)) ? '0 : v_next + 10'd1;
    row_calc = 9'(line_n / vcount_t'(SCALE)) + 9'd1;
    de_next  = h_act && v_act;
    swap_hit = pix_ce && (h_next == hcount_t'(H_ACTIVE)) &&
               (line_n < vcount_t'(V_ACTIVE)) && ((line_n % vcount_t'(SCALE)) == '0);
    vbs_hit  = pix_ce && (h_next == '0) && (v_next == vcount_t'(V_ACTIVE));
    soon_hit = pix_ce && (h_next == '0) && (v_next == vcount_t'(V_TOTAL - SOON_LINES));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid.vga_de          <= 1'b0;
      vid.vga_hs          <= ~HS_LVL;
      vid.vga_vs          <= ~VS_LVL;
      vid.pixel_x         <= '0;
      vid.pixel_y         <= '0;
      vid.rowram_swap     <= 1'b0;
      vid.next_row        <= '0;
      vid.vblank_start    <= 1'b0;
      vid.vblank_end_soon <= 1'b0;
    end else begin
      vid.vga_de          <= de_next;
      vid.vga_hs          <= h_sync;
      vid.vga_vs          <= v_sync;
      vid.rowram_swap     <= swap_hit;
      vid.vblank_start    <= vbs_hit;
      vid.vblank_end_soon <= soon_hit;
      if (de_next) begin
        vid.pixel_x <= h_next / hcount_t'(SCALE);
        vid.pixel_y <= v_next / vcount_t'(SCALE);
      end
      if (swap_hit) begin
        vid.next_row <= (row_calc == 9'(ROWS)) ? 8'd0 : row_calc[7:0];
      end
    end
  end

`ifdef VTG_FRAME_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vid.frame_count <= '0;
    end else if (vbs_hit) begin
      vid.frame_count <= vid.frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - scoreboard bench for video_timing_gen on a reduced 24x13 raster.
module tb_video_timing_gen;
  import video_timing_pkg::*;

  localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VSY = 2, VBP = 2;
  localparam int SC = 2,  SOON = 2;
  localparam int FRAME = 312;
  localparam int LAST_K = 904;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;

  video_timing_gen_if vid();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .SCALE(SC), .SOON_LINES(SOON), .HS_POL(0), .VS_POL(0)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .vid(vid)
  );

  always #5 clk = ~clk;

  typedef struct {int k; int kind; int row;} ev_t;
  typedef struct {int k; int de; int hs; int vs; int px; int py;} snap_t;

  ev_t   ev_q[$];
  snap_t snap_q[$];
  bit    snap_done = 1'b0;
  int    checks = 0;
  int    errors = 0;
  int    ce_cnt = 0;
  int    vbs_seen = 0;
  logic  prev_de = 1'b0;

  // One frame of events, k = pix_ce edges since reset release; kinds 0 vbs, 1 soon, 2 swap, 3 de rise.
  int tk   [14] = '{1, 73, 113, 121, 145, 161, 169, 193, 209, 217, 241, 257, 265, 289};
  int tkind[14] = '{0, 1,  2,   3,   3,   2,   3,   3,   2,   3,   3,   2,   3,   3};
  int trow [14] = '{0, 0,  1,   0,   0,   2,   0,   0,   3,   0,   0,   0,   0,   0};

  int sk [13] = '{25, 72, 73, 121, 136, 137, 139, 141, 142, 198, 432, 473, 904};
  int sde[13] = '{0,  0,  0,  1,   1,   0,   0,   0,   0,   1,   0,   0,   1};
  int shs[13] = '{1,  1,  1,  1,   1,   1,   0,   0,   1,   1,   1,   1,   1};
  int svs[13] = '{0,  0,  1,  1,   1,   1,   1,   1,   1,   1,   1,   1,   1};
  int spx[13] = '{0,  0,  0,  0,   7,   7,   7,   7,   7,   2,   7,   7,   7};
  int spy[13] = '{0,  0,  0,  0,   0,   0,   0,   0,   0,   1,   3,   0,   3};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic got_event(input int kind, input int row);
    ev_t e;
    checks++;
    if (ev_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_strobe: kind %0d at k=%0d, none expected", kind, ce_cnt);
    end else begin
      e = ev_q.pop_front();
      if (e.kind != kind || e.k != ce_cnt || e.row != row) begin
        errors++;
        $display("FAIL strobe: got kind %0d k=%0d row %0d expected kind %0d k=%0d row %0d",
                 kind, ce_cnt, row, e.kind, e.k, e.row);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_de"}, int'(vid.vga_de), 0);
    check({tag, "_hs"}, int'(vid.vga_hs), 1);
    check({tag, "_vs"}, int'(vid.vga_vs), 1);
    check({tag, "_px"}, int'(vid.pixel_x), 0);
    check({tag, "_py"}, int'(vid.pixel_y), 0);
    check({tag, "_next_row"}, int'(vid.next_row), 0);
    check({tag, "_strobes"}, int'({vid.rowram_swap, vid.vblank_start, vid.vblank_end_soon}), 0);
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) ce_cnt <= 0;
    else if (pix_ce) ce_cnt <= ce_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      vbs_seen = 0;
    end else begin
      if (vid.vblank_start) begin
        got_event(0, 0);
        vbs_seen++;
`ifdef VTG_FRAME_COUNT_EN
        check("frame_count", int'(vid.frame_count), vbs_seen & 16'hFFFF);
`endif
      end
      if (vid.vblank_end_soon) got_event(1, 0);
      if (vid.rowram_swap) got_event(2, int'(vid.next_row));
      if (vid.vga_de && !prev_de) got_event(3, 0);
      if (snap_q.size() > 0) begin
        if (ce_cnt == snap_q[0].k) begin
          check($sformatf("snap%0d_de", snap_q[0].k), int'(vid.vga_de), snap_q[0].de);
          check($sformatf("snap%0d_hs", snap_q[0].k), int'(vid.vga_hs), snap_q[0].hs);
          check($sformatf("snap%0d_vs", snap_q[0].k), int'(vid.vga_vs), snap_q[0].vs);
          check($sformatf("snap%0d_px", snap_q[0].k), int'(vid.pixel_x), snap_q[0].px);
          check($sformatf("snap%0d_py", snap_q[0].k), int'(vid.pixel_y), snap_q[0].py);
          snap_done = 1'b1;
        end else if (snap_done) begin
          void'(snap_q.pop_front());
          snap_done = 1'b0;
        end else if (ce_cnt > snap_q[0].k) begin
          check("snapshot_missed", ce_cnt, snap_q[0].k);
          void'(snap_q.pop_front());
        end
      end
    end
    prev_de = vid.vga_de;
  end

  initial begin
    ev_t   e;
    snap_t s;

    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("released");

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 14; i++) begin
        if (tk[i] + FRAME * f <= LAST_K) begin
          e.k = tk[i] + FRAME * f;
          e.kind = tkind[i];
          e.row = trow[i];
          ev_q.push_back(e);
        end
      end
    end
    for (int i = 0; i < 13; i++) begin
      s.k = sk[i]; s.de = sde[i]; s.hs = shs[i]; s.vs = svs[i]; s.px = spx[i]; s.py = spy[i];
      snap_q.push_back(s);
    end

    // Every other clk normally; a 100-clk freeze right after the swap at k=473; held high for k 700..799.
    for (int k = 1; k <= LAST_K; k++) begin
      pix_ce = 1'b1;
      @(negedge clk);
      if (k == 473) begin
        pix_ce = 1'b0;
        repeat (100) @(negedge clk);
      end else if (k < 700 || k >= 800) begin
        pix_ce = 1'b0;
        @(negedge clk);
      end
    end

    check("events_before_reset", ev_q.size(), 0);
    #2 rst = 1'b1;
    #1 check_idle("async_reset");
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    e.k = 1; e.kind = 0; e.row = 0;
    ev_q.push_back(e);
    pix_ce = 1'b1;
    @(negedge clk);
    pix_ce = 1'b0;
    repeat (4) @(negedge clk);

    check("events_left", ev_q.size(), 0);
    check("snapshots_left", snap_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
